// File: rtl/div_period_meter.sv
// Period meter for a divided-down signal: times NUM_PERIODS rising edges of sig_in in clk cycles.
// Optional registered tolerance check enabled by defining PERIOD_MATCH_EN.
module div_period_meter #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned NUM_PERIODS = 1,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned EXPECTED    = 113,
   parameter int unsigned TOL         = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             start,
   output logic             busy,
   output logic             valid,
   output logic [CNT_W-1:0] period,
   output logic             overflow,
   output logic             match
);

   localparam int unsigned      EW        = (NUM_PERIODS > 1) ? $clog2(NUM_PERIODS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [EW-1:0]    LAST_EDGE = EW'(NUM_PERIODS - 1);

   typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_d_q;
   logic                   rise;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       period_q, period_d;
   logic [EW-1:0]          edges_q, edges_d;
   logic                   valid_q, valid_d;
   logic                   ovf_q, ovf_d;
   logic                   done_hit;

   assign rise = sync_q[SYNC_STAGES-1] & ~s_d_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sync_q   <= '0;
         s_d_q    <= 1'b0;
         cnt_q    <= '0;
         period_q <= '0;
         edges_q  <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in};
         s_d_q    <= sync_q[SYNC_STAGES-1];
         cnt_q    <= cnt_d;
         period_q <= period_d;
         edges_q  <= edges_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      edges_d  = edges_q;
      valid_d  = valid_q;
      ovf_d    = ovf_q;
      done_hit = 1'b0;
      // start overrides any state and any coincident edge
      if (start) begin
         state_d = ARM;
         cnt_d   = '0;
         edges_d = '0;
         valid_d = 1'b0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: ;
            ARM: begin
               if (rise) begin
                  state_d = COUNT;
                  cnt_d   = CNT_W'(1);
                  edges_d = '0;
               end
            end
            COUNT: begin
               if (rise && (edges_q == LAST_EDGE)) begin
                  state_d  = DONE;
                  period_d = cnt_q;
                  valid_d  = 1'b1;
                  done_hit = 1'b1;
               end else begin
                  if (rise) edges_d = edges_q + EW'(1);
                  if (cnt_q != CNT_MAX) begin
                     cnt_d = cnt_q + CNT_W'(1);
                     if (cnt_q == (CNT_MAX - CNT_W'(1))) ovf_d = 1'b1;
                  end
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   assign busy     = (state_q == ARM) || (state_q == COUNT);
   assign valid    = valid_q;
   assign period   = period_q;
   assign overflow = ovf_q;

`ifdef PERIOD_MATCH_EN
   localparam logic [63:0] EXP_TOT = 64'(EXPECTED) * 64'(NUM_PERIODS);

   logic [63:0] cnt_ext, diff;
   logic        match_q;

   assign cnt_ext = 64'(cnt_q);
   assign diff    = (cnt_ext >= EXP_TOT) ? (cnt_ext - EXP_TOT) : (EXP_TOT - cnt_ext);

   always_ff @(posedge clk) begin
      if (rst || start)  match_q <= 1'b0;
      else if (done_hit) match_q <= !ovf_q && (diff <= 64'(TOL));
   end

   assign match = match_q;
`else
   logic unused_match_cfg;

   // comparator parameters only matter when the match feature is built in
   assign unused_match_cfg = ^{EXPECTED, TOL, done_hit};
   assign match            = 1'b0;
`endif

endmodule
